// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues one PC read at a time to instruction memory and buffers
// {pc, instr, misalign} entries for decode, with redirect flush and misaligned-PC tagging.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_misalign
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [AW:0] Full   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CntOne = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pending_pc_q, pending_pc_d;

    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_instr [DEPTH];
    logic        mem_mis   [DEPTH];

    logic        accept;
    logic        aligned;
    logic        push;
    logic        pop;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        push_mis;

    assign aligned   = (pc_in[1:0] == 2'b00);
    assign pc_ready  = (state_q == StIdle) && (count_q < Full) && !flush && !clr;
    assign accept    = pc_valid && pc_ready;
    assign imem_req  = accept && aligned;
    assign imem_addr = pc_in;

    assign id_valid    = (count_q != '0);
    assign id_pc       = mem_pc[rd_ptr_q];
    assign id_instr    = mem_instr[rd_ptr_q];
    assign id_misalign = mem_mis[rd_ptr_q];
    assign pop         = id_valid && id_ready;

    always_comb begin
        state_d      = state_q;
        pending_pc_d = pending_pc_q;
        push         = 1'b0;
        push_pc      = '0;
        push_instr   = '0;
        push_mis     = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (aligned) begin
                        pending_pc_d = pc_in;
                        state_d      = StWait;
                    end else begin
                        // Misaligned PCs never reach memory; queue a tagged bubble.
                        push     = 1'b1;
                        push_pc  = pc_in;
                        push_mis = 1'b1;
                    end
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StIdle;
                    if (!flush) begin
                        push       = 1'b1;
                        push_pc    = pending_pc_q;
                        push_instr = imem_rdata;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (imem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= StIdle;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && !flush && push) begin
            mem_pc[wr_ptr_q]    <= push_pc;
            mem_instr[wr_ptr_q] <= push_instr;
            mem_mis[wr_ptr_q]   <= push_mis;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, single fetch, fill/back-pressure, flush, misaligned
// tagging and sustained push/pop across pointer wrap.
module tb_fetch_queue;

    logic        clk;
    logic        clr;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .clr         (clr),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_misalign (id_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; pc_valid = 1'b1; pc_in = 32'h0040_0000; flush = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
            n_checks++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        end
        clr = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL post_reset_addr: got %h want 00400000", imem_addr); end
    endtask

    task automatic test_single_fetch();
        tick();                      // request accepted
        pc_valid = 1'b0;
        #1;
        n_checks++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL wait_pc_ready: got %b want 0", pc_ready); end
        tick();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_000A;
        #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL pre_resp_id_valid: got %b want 0", id_valid); end
        tick();
        imem_rvalid = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL single_id_valid: got %b want 1", id_valid); end
        n_checks++; if (id_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL single_id_pc: got %h want 00400000", id_pc); end
        n_checks++; if (id_instr !== 32'h2008_000A) begin n_fail++; $display("FAIL single_id_instr: got %h want 2008000a", id_instr); end
        n_checks++; if (id_misalign !== 1'b0) begin n_fail++; $display("FAIL single_misalign: got %b want 0", id_misalign); end
        n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL single_pc_ready: got %b want 1", pc_ready); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_empty: got %b want 0", id_valid); end
    endtask

    task automatic test_fill_backpressure();
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'h0040_0000 + 32'(4 * i); pc_valid = 1'b1;
            #1;
            n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b want 1", i, pc_ready); end
            n_checks++; if (imem_addr !== pc_in) begin n_fail++; $display("FAIL fill_addr_%0d: got %h want %h", i, imem_addr, pc_in); end
            tick();
            pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1000 + 32'(i);
            tick();
            imem_rvalid = 1'b0;
        end
        pc_valid = 1'b1; pc_in = 32'h0040_0010;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL full_pc_ready_%0d: got %b want 0", i, pc_ready); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_imem_req_%0d: got %b want 0", i, imem_req); end
            tick();
        end
        id_ready = 1'b1;
        #1;
        n_checks++; if (id_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL pop0_pc: got %h want 00400000", id_pc); end
        tick();
        n_checks++; if (id_pc !== 32'h0040_0004) begin n_fail++; $display("FAIL pop1_pc: got %h want 00400004", id_pc); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL resume_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0040_0010) begin n_fail++; $display("FAIL resume_addr: got %h want 00400010", imem_addr); end
        tick();
        pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_5555;
        #1;
        n_checks++; if (id_pc !== 32'h0040_0008) begin n_fail++; $display("FAIL pop2_pc: got %h want 00400008", id_pc); end
        tick();
        imem_rvalid = 1'b0;
        #1;
        n_checks++; if (id_pc !== 32'h0040_000C) begin n_fail++; $display("FAIL pop3_pc: got %h want 0040000c", id_pc); end
        tick();
        n_checks++; if (id_pc !== 32'h0040_0010) begin n_fail++; $display("FAIL pop4_pc: got %h want 00400010", id_pc); end
        n_checks++; if (id_instr !== 32'h0000_5555) begin n_fail++; $display("FAIL pop4_instr: got %h want 00005555", id_instr); end
        tick();
        id_ready = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got %b want 0", id_valid); end
    endtask

    task automatic test_flush_inflight();
        pc_in = 32'h0040_0010; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0; flush = 1'b1;
        #1;
        n_checks++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_ready: got %b want 0", pc_ready); end
        tick();
        flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h0040_0100;
        #1;
        n_checks++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_a: got %b want 0", pc_ready); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_req: got %b want 0", imem_req); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_b: got %b want 0", pc_ready); end
        tick();
        imem_rvalid = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_not_queued: got %b want 0", id_valid); end
        n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL after_drop_ready: got %b want 1", pc_ready); end
        n_checks++; if (imem_addr !== 32'h0040_0100) begin n_fail++; $display("FAIL redirect_addr: got %h want 00400100", imem_addr); end
        tick();
        pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_valid: got %b want 1", id_valid); end
        n_checks++; if (id_pc !== 32'h0040_0100) begin n_fail++; $display("FAIL redirect_pc: got %h want 00400100", id_pc); end
        n_checks++; if (id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL redirect_instr: got %h want 00000013", id_instr); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    task automatic test_flush_queue();
        pc_valid = 1'b1; pc_in = 32'h0040_0203;
        tick();
        pc_in = 32'h0040_0207;
        tick();
        pc_valid = 1'b0; flush = 1'b1; id_ready = 1'b1;
        tick();
        flush = 1'b0; id_ready = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_queue_empty: got %b want 0", id_valid); end
        n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_queue_ready: got %b want 1", pc_ready); end
    endtask

    task automatic test_misaligned();
        pc_in = 32'h0040_0002; pc_valid = 1'b1;
        #1;
        n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL mis_ready: got %b want 1", pc_ready); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_imem_req: got %b want 0", imem_req); end
        tick();
        pc_valid = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %b want 1", id_valid); end
        n_checks++; if (id_pc !== 32'h0040_0002) begin n_fail++; $display("FAIL mis_pc: got %h want 00400002", id_pc); end
        n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL mis_instr: got %h want 00000000", id_instr); end
        n_checks++; if (id_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", id_misalign); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = 32'h0040_0001;
        pc_valid = 1'b1; pc_in = base;
        tick();
        pc_in = base + 32'd4;
        tick();
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_in = base + 32'(4 * (i + 2));
            #1;
            n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %b want 1", i, id_valid); end
            n_checks++; if (id_pc !== base + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_pc_%0d: got %h want %h", i, id_pc, base + 32'(4 * i)); end
            n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want 1", i, pc_ready); end
            tick();
        end
        pc_valid = 1'b0;
        #1;
        n_checks++; if (id_pc !== base + 32'd40) begin n_fail++; $display("FAIL b2b_tail0: got %h want %h", id_pc, base + 32'd40); end
        tick();
        n_checks++; if (id_pc !== base + 32'd44) begin n_fail++; $display("FAIL b2b_tail1: got %h want %h", id_pc, base + 32'd44); end
        tick();
        id_ready = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", id_valid); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_fill_backpressure();
        test_flush_inflight();
        test_flush_queue();
        test_misaligned();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
